// File: rtl/sqrt_pkg.sv
// Shared definitions for the sum-of-squares stage and the square-root stage it feeds.
package sqrt_pkg;

  localparam int IN_W_DEF = 15;
  localparam int OUT_W    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ_A = 2'd1,
    SQ_B = 2'd2,
    DONE = 2'd3
  } state_e;

  // Step counter width; at least one bit even for degenerate operand widths.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sum_squares_seq_if.sv
// Start/busy/valid handshake carrying the operands in and the result out.
interface sum_squares_seq_if
  import sqrt_pkg::*;
#(
  parameter int IN_W = IN_W_DEF
);

  logic             start;
  logic [IN_W-1:0]  a;
  logic [IN_W-1:0]  b;
  logic             busy;
  logic             valid;
  logic [OUT_W-1:0] res;

  modport master (output start, a, b, input busy, valid, res);
  modport slave  (input start, a, b, output busy, valid, res);

endinterface

// File: rtl/sum_squares_seq_shift_add_step.sv
// One combinational shift-add multiply step, shared by both squaring passes.
module shift_add_step
  import sqrt_pkg::*;
#(
  parameter int IN_W = IN_W_DEF
) (
  input  logic [OUT_W-1:0] acc_i,
  input  logic [OUT_W-1:0] mcand_i,
  input  logic [IN_W-1:0]  mplier_i,
  output logic [OUT_W-1:0] acc_o,
  output logic [OUT_W-1:0] mcand_o,
  output logic [IN_W-1:0]  mplier_o
);

  assign acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
  assign mcand_o  = mcand_i << 1;
  assign mplier_o = mplier_i >> 1;

endmodule

// File: rtl/sum_squares_seq.sv
// Multicycle res = a*a + b*b: squares a then b with one shift-add step per clock,
// accumulating both into a single 32-bit sum.
module sum_squares_seq
  import sqrt_pkg::*;
#(
  parameter int IN_W = IN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  sum_squares_seq_if.slave bus
);

  localparam int CNT_W = cnt_width(IN_W);

  if (2 * IN_W + 1 > OUT_W) begin : g_width_check
    $error("sum_squares_seq: 2*IN_W+1 must not exceed OUT_W");
  end

  state_e           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] mcand_q, mcand_d;
  logic [IN_W-1:0]  mplier_q, mplier_d;
  logic [IN_W-1:0]  b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] res_q, res_d;

  logic [OUT_W-1:0] step_acc;
  logic [OUT_W-1:0] step_mcand;
  logic [IN_W-1:0]  step_mplier;
  logic             cnt_last;

  shift_add_step #(.IN_W(IN_W)) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (step_acc),
    .mcand_o  (step_mcand),
    .mplier_o (step_mplier)
  );

  assign cnt_last = (cnt_q == CNT_W'(IN_W - 1));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    res_d    = res_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d  = OUT_W'(bus.a);
          mplier_d = bus.a;
          b_d      = bus.b;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = SQ_A;
        end
      end

      SQ_A: begin
        acc_d = step_acc;
        if (cnt_last) begin
          // Second pass reuses the same step logic on the latched b.
          mcand_d  = OUT_W'(b_q);
          mplier_d = b_q;
          cnt_d    = '0;
          state_d  = SQ_B;
        end else begin
          mcand_d  = step_mcand;
          mplier_d = step_mplier;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end

      SQ_B: begin
        acc_d    = step_acc;
        mcand_d  = step_mcand;
        mplier_d = step_mplier;
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        res_d   = acc_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      res_q    <= res_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.res   = res_q;

endmodule

// File: tb/tb_sum_squares_seq.sv
// Self-checking bench for sum_squares_seq: directed scenarios plus randomized
// operands against an arithmetic reference model.
module tb_sum_squares_seq;
  import sqrt_pkg::*;

  localparam int IN_W = IN_W_DEF;
  localparam int LAT  = 2 * IN_W + 1;
  localparam int MAXV = (1 << IN_W) - 1;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  sum_squares_seq_if #(.IN_W(IN_W)) bus ();

  sum_squares_seq #(.IN_W(IN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input int unsigned a, input int unsigned b);
    return 64'(a) * 64'(a) + 64'(b) * 64'(b);
  endfunction

  // Called at a negedge; returns at the negedge where valid is seen (or the bound expires).
  task automatic run_op(input string tag, input int unsigned a, input int unsigned b,
                        input bit disturb);
    logic [OUT_W-1:0] held;
    int n;
    bit busy_ok, hold_ok;
    held      = bus.res;
    bus.start = 1'b1;
    bus.a     = IN_W'(a);
    bus.b     = IN_W'(b);
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, " busy_on"}, 64'(bus.busy), 64'd1);
    check({tag, " valid_low"}, 64'(bus.valid), 64'd0);
    n = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    while (bus.valid !== 1'b1 && n < 100) begin
      if (disturb) begin
        bus.a     = IN_W'($urandom_range(0, MAXV));
        bus.b     = IN_W'($urandom_range(0, MAXV));
        bus.start = (n == 9);
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.res !== held)  hold_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    check({tag, " latency"}, 64'(n), 64'(LAT));
    check({tag, " res"}, 64'(bus.res), model(a, b));
    check({tag, " busy_off"}, 64'(bus.busy), 64'd0);
    check({tag, " busy_held"}, 64'(busy_ok), 64'd1);
    check({tag, " res_held"}, 64'(hold_ok), 64'd1);
  endtask

  // Advance n cycles and require that no valid pulse appears.
  task automatic idle_watch(input string tag, input int n);
    int pulses;
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.valid !== 1'b0) pulses++;
    end
    check({tag, " no_valid"}, 64'(pulses), 64'd0);
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset valid", 64'(bus.valid), 64'd0);
    check("reset res", 64'(bus.res), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle busy", 64'(bus.busy), 64'd0);

    run_op("basic", 3, 4, 1'b0);
    idle_watch("basic pulse", 1);
    run_op("zero", 0, 0, 1'b0);
    idle_watch("zero pulse", 1);
    run_op("max", MAXV, MAXV, 1'b0);
    idle_watch("max pulse", 1);

    run_op("ignore", 5, 12, 1'b1);
    idle_watch("ignore", 40);

    run_op("b2b first", 6, 8, 1'b0);
    run_op("b2b second", 1, 2, 1'b0);
    idle_watch("b2b", 2);

    bus.start = 1'b1; bus.a = IN_W'(100); bus.b = IN_W'(200);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort valid", 64'(bus.valid), 64'd0);
    check("abort res", 64'(bus.res), 64'd0);
    idle_watch("abort", 40);
    run_op("after abort", 7, 24, 1'b0);
    idle_watch("after abort", 1);

    rst = 1'b1; bus.start = 1'b1; bus.a = IN_W'(9); bus.b = IN_W'(9);
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    check("rst_start busy", 64'(bus.busy), 64'd0);
    check("rst_start res", 64'(bus.res), 64'd0);
    idle_watch("rst_start", 40);

    for (int i = 0; i < 20; i++) begin
      int unsigned ra, rb;
      ra = $urandom_range(0, MAXV);
      rb = $urandom_range(0, MAXV);
      run_op($sformatf("rand%0d", i), ra, rb, 1'b0);
      if ($urandom_range(0, 1) == 0) idle_watch($sformatf("rand%0d", i), $urandom_range(1, 4));
    end
    idle_watch("final", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sum_squares_seq.md
Name: sum_squares_seq

Overview:
- Multicycle sequential block that computes res = a*a + b*b on unsigned operands using a shift-add squarer.
- Sits directly upstream of the combinational integer square-root stage: its 32-bit res drives that stage's 32-bit input, so the pair yields the Euclidean magnitude of (a, b).
- Uses a start/busy/valid handshake so the top level can hold operands and capture the result.

Parameters:
- IN_W, 15, operand width in bits. Constraint: 2*IN_W+1 <= 32, so the result never exceeds 32 bits.
- OUT_W, 32, result width. Matches the square-root stage input width and is fixed at 32.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- a  in  IN_W  first operand, unsigned; latched on the accepted start.
- b  in  IN_W  second operand, unsigned; latched on the accepted start.
- busy  out  1  high while a computation is in flight.
- valid  out  1  one-cycle pulse when res is updated.
- res  out  OUT_W  a*a + b*b, zero-extended; held until the next result or reset.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: all registers clear on any rising edge with rst=1, including mid-operation (the computation is aborted). Outputs after reset: busy=0, valid=0, res=0, state=IDLE.
- FSM states: IDLE, SQ_A, SQ_B, DONE.
- IDLE:
  - start=1 at edge t0 latches mcand = a (zero-extended to OUT_W), mplier = a, acc = 0, cnt = 0.
  - Transitions to SQ_A; busy=1 from t0.
- SQ_A (edges t0+1 .. t0+IN_W):
  - Each edge: if mplier[0] then acc += mcand; then mcand <<= 1, mplier >>= 1, cnt++.
  - When cnt reaches IN_W-1: reload mcand = b, mplier = b, cnt = 0 (acc retained); go to SQ_B.
- SQ_B (edges t0+IN_W+1 .. t0+2*IN_W): same step as SQ_A. When cnt reaches IN_W-1, go to DONE.
- DONE (edge t0+2*IN_W+1): res <= acc, valid <= 1, busy <= 0, go to IDLE.
- Latency: fixed 2*IN_W+1 cycles from the accepted start to valid (31 cycles at IN_W=15), independent of operand values.
- valid: high for exactly one cycle; deasserted on the following edge.
- start while busy=1: ignored; no queueing and no effect on the in-flight result.
- Back-to-back: start asserted in the same cycle valid=1 is visible (state is IDLE) is accepted. The new result arrives 2*IN_W+1 cycles later, and the old res stays held until then.
- Operand stability: a and b changing while busy=1 has no effect (latched copies only).
- Arithmetic:
  - acc is OUT_W bits with no overflow by construction. Maximum at IN_W=15 is 2*32767^2 = 2147352578 < 2^32.
  - Zero operands still take the full latency.
- rst and start both high on the same edge: reset wins; start is dropped.

Decomposition:
- Shared package (sqrt_pkg), holding:
  - the state encoding (IDLE=2'd0, SQ_A=2'd1, SQ_B=2'd2, DONE=2'd3);
  - IN_W default 15;
  - OUT_W = 32.
  The square-root stage uses the same OUT_W.
- One natural sub-module: shift_add_step.
  - Combinational single step: {acc, mcand, mplier} -> next values.
  - Instantiated once and reused for both squares; the top holds the FSM, counter and result register.

Test Plan:
- Basic case: reset, then start with a=3, b=4 → busy=1 for 31 cycles; valid pulses once at cycle 31 with res=25. Feeding res to the square-root stage gives 5.
- Zero/max operands:
  - a=0, b=0 → res=0 after 31 cycles.
  - a=32767, b=32767 → res=2147352578, with no wrap.
- Busy behaviour: start a=5, b=12, then pulse start with a=1, b=1 at cycle 10 and change a/b during busy → res=169; exactly one valid pulse.
- Back-to-back: start a=6, b=8; assert start with a=1, b=2 in the cycle valid=1 → res=100, then res=5 exactly 31 cycles later. res holds 100 in between.
- Reset mid-operation: start a=100, b=200, assert rst at cycle 15 → next cycle busy=0, valid=0, res=0; no valid pulse follows. A fresh start with a=7, b=24 → res=625.
